// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for the 5-stage RV32I pipeline.
// It drives the stall, bubble and flush controls around execute, plus the operand
// forwarding selects. It freezes the pipe during data-memory wait states and keeps
// stall/flush cycle counters.
//
// Build option: FORWARDING_EN
//   defined   - EX/MEM and MEM/WB forwarding is active; only load-use hazards stall.
//   undefined - forwarding selects are tied to 00; any RAW dependency on ex/mem/wb stalls.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; hazards, redirects and memory waits evaluated
// MEM_WAIT | data memory busy, whole pipeline frozen
// FLUSH    | post-redirect window, IF/ID killed while flush_left runs down
//
// Stalls, bubbles and flushes are Mealy outputs: they must act in the same cycle
// as the hazard, memory wait or redirect that causes them.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_num,
   input  logic [4:0]       id_rs2_num,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd_num,
   input  logic             ex_reg_write,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_rd_num,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd_num,
   input  logic             wb_reg_write,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // A redirect counts its own RUN cycle as the first flush cycle, so it loads one
   // less than a flush that starts after a memory wait. Either way the IF/ID kill
   // lasts FLUSH_CYCLES cycles in total.
   localparam logic [2:0] FL_LOAD_REDIR = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] FL_LOAD_WAIT  = 3'(FLUSH_CYCLES);
   localparam bit         FL_MULTI      = (FLUSH_CYCLES > 1);

   state_t     state;
   logic [2:0] flush_left;
   logic       pend_flush;

   logic src1_ok;
   logic src2_ok;
   logic ex_hit;
   logic load_use;
   logic data_stall;
   logic mem_wait;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // Decode source matching against in-flight destinations; x0 never matches.
   always_comb begin
      src1_ok  = id_uses_rs1 && (id_rs1_num != 5'd0);
      src2_ok  = id_uses_rs2 && (id_rs2_num != 5'd0);
      ex_hit   = ex_reg_write && (ex_rd_num != 5'd0) &&
                 ((src1_ok && (id_rs1_num == ex_rd_num)) ||
                  (src2_ok && (id_rs2_num == ex_rd_num)));
      load_use = ex_is_load && ex_hit;
      mem_wait = mem_req && !mem_ready;
   end

`ifdef FORWARDING_EN
   // Forward selects: memory stage is younger, so it wins over writeback.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_reg_write && (mem_rd_num != 5'd0) && (mem_rd_num == id_rs1_num))
         fwd_a = 2'b01;
      else if (wb_reg_write && (wb_rd_num != 5'd0) && (wb_rd_num == id_rs1_num))
         fwd_a = 2'b10;
      if (mem_reg_write && (mem_rd_num != 5'd0) && (mem_rd_num == id_rs2_num))
         fwd_b = 2'b01;
      else if (wb_reg_write && (wb_rd_num != 5'd0) && (wb_rd_num == id_rs2_num))
         fwd_b = 2'b10;
      data_stall = load_use;
   end
`else
   // Without forwarding, a source must wait until its producer has left writeback.
   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = mem_reg_write && (mem_rd_num != 5'd0) &&
                ((src1_ok && (id_rs1_num == mem_rd_num)) ||
                 (src2_ok && (id_rs2_num == mem_rd_num)));
      wb_hit  = wb_reg_write && (wb_rd_num != 5'd0) &&
                ((src1_ok && (id_rs1_num == wb_rd_num)) ||
                 (src2_ok && (id_rs2_num == wb_rd_num)));
      data_stall = load_use || ex_hit || mem_hit || wb_hit;
      fwd_a      = 2'b00;
      fwd_b      = 2'b00;
   end
`endif

   // Pipeline controls; priority is memory wait, then redirect, then data hazard.
   always_comb begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      fwd_a_sel   = 2'b00;
      fwd_b_sel   = 2'b00;
      if (rst_n) begin
         fwd_a_sel = fwd_a;
         fwd_b_sel = fwd_b;
         case (state)
            RUN: begin
               if (mem_wait) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  stall_mem = 1'b1;
               end else if (branch_taken) begin
                  flush_if_id = 1'b1;
                  bubble_ex   = 1'b1;
               end else if (data_stall) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  stall_mem = 1'b1;
               end
            end
            FLUSH: begin
               flush_if_id = 1'b1;
               if (mem_wait) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_ex  = 1'b1;
                  stall_mem = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Sequencing state, flush down-counter and the flush deferred across a memory wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         flush_left <= 3'd0;
         pend_flush <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_wait) begin
                  state      <= MEM_WAIT;
                  pend_flush <= branch_taken;
               end else if (branch_taken) begin
                  flush_left <= FL_LOAD_REDIR;
                  if (FL_MULTI)
                     state <= FLUSH;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  pend_flush <= 1'b0;
                  if (pend_flush) begin
                     state      <= FLUSH;
                     flush_left <= FL_LOAD_WAIT;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            FLUSH: begin
               if (!mem_wait) begin
                  flush_left <= flush_left - 3'd1;
                  if (flush_left <= 3'd1)
                     state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Performance counters, free-running and wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_if_id)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
